// File: rtl/mem_arbiter_if.sv
// Pipeline/RAM side signals of the byte-wide memory arbiter.
// master: the arbiter itself; slave: pipeline stages plus RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic [7:0]            ram_din;
  logic [7:0]            ram_dout;
  logic [ADDR_WIDTH-1:0] ram_a;
  logic                  ram_wr;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_clear;
  logic                  if_available;
  logic [31:0]           if_inst;

  logic [ADDR_WIDTH-1:0] mem_addr_i;
  logic                  mem_wr_i;
  logic [31:0]           mem_data_i;
  logic [1:0]            mem_cnf_i;
  logic                  addr_needed;
  logic                  mem_available;
  logic                  mem_working;
  logic [31:0]           mem_rdata;

  modport master (
    input  ram_din, if_req, if_addr, if_clear,
           mem_addr_i, mem_wr_i, mem_data_i, mem_cnf_i,
    output ram_dout, ram_a, ram_wr, if_available, if_inst,
           addr_needed, mem_available, mem_working, mem_rdata
  );

  modport slave (
    output ram_din, if_req, if_addr, if_clear,
           mem_addr_i, mem_wr_i, mem_data_i, mem_cnf_i,
    input  ram_dout, ram_a, ram_wr, if_available, if_inst,
           addr_needed, mem_available, mem_working, mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between IF and MEM (MEM has priority),
// splitting each access into 1/2/4 byte transfers assembled little-endian.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus
);
  localparam int unsigned AW = ADDR_WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state,   w_state_nxt;
  logic [2:0]    r_cnt,     w_cnt_nxt;
  logic [2:0]    r_n,       w_n_nxt;
  logic          r_own_mem, w_own_mem_nxt;
  logic          r_wr,      w_wr_nxt;
  logic          r_clr,     w_clr_nxt;
  logic [AW-1:0] r_base,    w_base_nxt;
  logic [31:0]   r_data,    w_data_nxt;
  logic [31:0]   r_result,  w_result_nxt;

  logic [AW-1:0] r_ram_a,         w_ram_a_nxt;
  logic [7:0]    r_ram_dout,      w_ram_dout_nxt;
  logic          r_ram_wr,        w_ram_wr_nxt;
  logic          r_addr_needed,   w_addr_needed_nxt;
  logic          r_mem_working,   w_mem_working_nxt;
  logic          r_mem_avail,     w_mem_avail_nxt;
  logic [31:0]   r_mem_rdata,     w_mem_rdata_nxt;
  logic          r_if_avail,      w_if_avail_nxt;
  logic [31:0]   r_if_inst,       w_if_inst_nxt;

  logic [1:0]    w_rd_byte;
  logic [1:0]    w_wr_byte;

  // Byte captured at count c belongs to result lane c-1.
  assign w_rd_byte = 2'(r_cnt - 3'd1);
  assign w_wr_byte = w_cnt_nxt[1:0];

  // Next-state, transaction bookkeeping and next registered outputs.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_n_nxt           = r_n;
    w_own_mem_nxt     = r_own_mem;
    w_wr_nxt          = r_wr;
    w_clr_nxt         = r_clr;
    w_base_nxt        = r_base;
    w_data_nxt        = r_data;
    w_result_nxt      = r_result;
    w_ram_a_nxt       = r_ram_a;
    w_ram_dout_nxt    = r_ram_dout;
    w_ram_wr_nxt      = 1'b0;
    w_addr_needed_nxt = 1'b0;
    w_mem_working_nxt = 1'b0;
    w_mem_avail_nxt   = 1'b0;
    w_mem_rdata_nxt   = r_mem_rdata;
    w_if_avail_nxt    = 1'b0;
    w_if_inst_nxt     = r_if_inst;

    case (r_state)
      S_IDLE: begin
        if (bus.mem_cnf_i != 2'd0) begin
          w_base_nxt    = bus.mem_addr_i;
          w_data_nxt    = bus.mem_data_i;
          w_wr_nxt      = bus.mem_wr_i;
          w_n_nxt       = (bus.mem_cnf_i == 2'd1) ? 3'd1 :
                          (bus.mem_cnf_i == 2'd2) ? 3'd2 : 3'd4;
          w_own_mem_nxt = 1'b1;
          w_cnt_nxt     = 3'd0;
          w_result_nxt  = 32'd0;
          w_clr_nxt     = 1'b0;
          w_state_nxt   = bus.mem_wr_i ? S_WRITE : S_READ;
        end else if (bus.if_req && !bus.if_clear) begin
          w_base_nxt    = bus.if_addr;
          w_wr_nxt      = 1'b0;
          w_n_nxt       = 3'd4;
          w_own_mem_nxt = 1'b0;
          w_cnt_nxt     = 3'd0;
          w_result_nxt  = 32'd0;
          w_clr_nxt     = 1'b0;
          w_state_nxt   = S_READ;
        end
      end
      S_READ: begin
        if (r_cnt != 3'd0) begin
          w_result_nxt[{w_rd_byte, 3'b000} +: 8] = bus.ram_din;
        end
        if (!r_own_mem && bus.if_clear) begin
          w_clr_nxt = 1'b1;
        end
        if (r_cnt == r_n) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      S_WRITE: begin
        if (r_cnt == r_n - 3'd1) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 3'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state.
    case (w_state_nxt)
      S_IDLE: begin
        w_addr_needed_nxt = 1'b1;
      end
      S_READ: begin
        w_ram_a_nxt = (w_cnt_nxt < w_n_nxt) ? w_base_nxt + AW'(w_cnt_nxt)
                                            : w_base_nxt + AW'(w_n_nxt - 3'd1);
        w_mem_working_nxt = w_own_mem_nxt;
      end
      S_WRITE: begin
        w_ram_wr_nxt      = 1'b1;
        w_ram_a_nxt       = w_base_nxt + AW'(w_cnt_nxt);
        w_ram_dout_nxt    = w_data_nxt[{w_wr_byte, 3'b000} +: 8];
        w_mem_working_nxt = w_own_mem_nxt;
      end
      default: begin
        w_mem_working_nxt = w_own_mem_nxt;
        if (w_own_mem_nxt) begin
          w_mem_avail_nxt = 1'b1;
          w_mem_rdata_nxt = w_wr_nxt ? 32'd0 : w_result_nxt;
        end else begin
          w_if_avail_nxt = !w_clr_nxt;
          w_if_inst_nxt  = w_clr_nxt ? 32'd0 : w_result_nxt;
        end
      end
    endcase
  end

  // State, transaction and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= 3'd0;
      r_n           <= 3'd0;
      r_own_mem     <= 1'b0;
      r_wr          <= 1'b0;
      r_clr         <= 1'b0;
      r_base        <= '0;
      r_data        <= 32'd0;
      r_result      <= 32'd0;
      r_ram_a       <= '0;
      r_ram_dout    <= 8'd0;
      r_ram_wr      <= 1'b0;
      r_addr_needed <= 1'b0;
      r_mem_working <= 1'b0;
      r_mem_avail   <= 1'b0;
      r_mem_rdata   <= 32'd0;
      r_if_avail    <= 1'b0;
      r_if_inst     <= 32'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_n           <= w_n_nxt;
      r_own_mem     <= w_own_mem_nxt;
      r_wr          <= w_wr_nxt;
      r_clr         <= w_clr_nxt;
      r_base        <= w_base_nxt;
      r_data        <= w_data_nxt;
      r_result      <= w_result_nxt;
      r_ram_a       <= w_ram_a_nxt;
      r_ram_dout    <= w_ram_dout_nxt;
      r_ram_wr      <= w_ram_wr_nxt;
      r_addr_needed <= w_addr_needed_nxt;
      r_mem_working <= w_mem_working_nxt;
      r_mem_avail   <= w_mem_avail_nxt;
      r_mem_rdata   <= w_mem_rdata_nxt;
      r_if_avail    <= w_if_avail_nxt;
      r_if_inst     <= w_if_inst_nxt;
    end
  end

  assign bus.ram_a         = r_ram_a;
  assign bus.ram_dout      = r_ram_dout;
  assign bus.ram_wr        = r_ram_wr;
  assign bus.addr_needed   = r_addr_needed;
  assign bus.mem_working   = r_mem_working;
  assign bus.mem_available = r_mem_avail;
  assign bus.mem_rdata     = r_mem_rdata;

  // A flush arriving during the DONE cycle itself still kills the fetch result.
  assign bus.if_available  = r_if_avail && !bus.if_clear;
  assign bus.if_inst       = (r_if_avail && bus.if_clear) ? 32'd0 : r_if_inst;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 512-byte RAM model (low 9 address bits).
module tb_mem_arbiter;
  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  mem_arbiter #(.ADDR_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] ram [0:511];
  logic       tb_we;
  logic [8:0] tb_wa;
  logic [7:0] tb_wd;

  // Synchronous-read RAM; bench preloads go through the same write port.
  always @(posedge clk) begin
    bus.ram_din <= ram[bus.ram_a[8:0]];
    if (bus.ram_wr) ram[bus.ram_a[8:0]] <= bus.ram_dout;
    else if (tb_we) ram[tb_wa] <= tb_wd;
  end

  int total = 0;
  int bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [7:0] d);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic mem_req(input logic [31:0] a, input logic wr, input logic [31:0] d,
                         input logic [1:0] cnf);
    bus.mem_addr_i = a;
    bus.mem_wr_i   = wr;
    bus.mem_data_i = d;
    bus.mem_cnf_i  = cnf;
  endtask

  initial begin
    rst            = 1'b0;
    tb_we          = 1'b0;
    tb_wa          = 9'd0;
    tb_wd          = 8'd0;
    bus.if_req     = 1'b0;
    bus.if_addr    = 32'd0;
    bus.if_clear   = 1'b0;
    mem_req(32'd0, 1'b0, 32'd0, 2'd0);
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;

    // Preload while held in reset
    poke(9'h100, 8'h11); poke(9'h101, 8'h22); poke(9'h102, 8'h33); poke(9'h103, 8'h44);
    poke(9'h1F1, 8'h5A);
    poke(9'h020, 8'h80); poke(9'h021, 8'hFF); poke(9'h022, 8'h77);
    poke(9'h000, 8'h13); poke(9'h001, 8'h05); poke(9'h002, 8'h00); poke(9'h003, 8'h00);
    poke(9'h040, 8'h01); poke(9'h041, 8'h02); poke(9'h042, 8'h03); poke(9'h043, 8'h04);
    poke(9'h1FF, 8'hEE);

    chk1 ("rst_ram_wr",      bus.ram_wr,        1'b0);
    chk1 ("rst_addr_needed", bus.addr_needed,   1'b0);
    chk1 ("rst_mem_working", bus.mem_working,   1'b0);
    chk1 ("rst_mem_avail",   bus.mem_available, 1'b0);
    chk1 ("rst_if_avail",    bus.if_available,  1'b0);
    chk32("rst_ram_a",       bus.ram_a,         32'd0);
    chk32("rst_mem_rdata",   bus.mem_rdata,     32'd0);

    rst = 1'b1;
    tick();
    chk1("idle_addr_needed", bus.addr_needed, 1'b1);

    // MEM word load at 0x100
    mem_req(32'h100, 1'b0, 32'd0, 2'd3);
    tick();
    mem_req(32'd0, 1'b0, 32'd0, 2'd0);
    chk32("wl_a0", bus.ram_a, 32'h100);
    chk1 ("wl_working0", bus.mem_working, 1'b1);
    chk1 ("wl_needed0",  bus.addr_needed, 1'b0);
    chk1 ("wl_wr0",      bus.ram_wr,      1'b0);
    tick(); chk32("wl_a1", bus.ram_a, 32'h101);
    tick(); chk32("wl_a2", bus.ram_a, 32'h102);
    tick(); chk32("wl_a3", bus.ram_a, 32'h103);
    tick(); chk1 ("wl_avail_c4", bus.mem_available, 1'b0);
    chk1 ("wl_working4", bus.mem_working, 1'b1);
    tick();
    chk1 ("wl_avail",   bus.mem_available, 1'b1);
    chk32("wl_rdata",   bus.mem_rdata,     32'h44332211);
    chk1 ("wl_needed",  bus.addr_needed,   1'b0);
    chk1 ("wl_working", bus.mem_working,   1'b1);
    tick();
    chk1 ("wl_avail_off",  bus.mem_available, 1'b0);
    chk1 ("wl_needed_idle", bus.addr_needed,  1'b1);
    chk1 ("wl_working_idle", bus.mem_working, 1'b0);
    chk32("wl_rdata_hold", bus.mem_rdata,     32'h44332211);

    // MEM byte store at 0x1F0
    mem_req(32'h1F0, 1'b1, 32'hABCDEF12, 2'd1);
    tick();
    mem_req(32'd0, 1'b0, 32'd0, 2'd0);
    chk1 ("bs_wr",   bus.ram_wr,   1'b1);
    chk32("bs_a",    bus.ram_a,    32'h1F0);
    chk32("bs_dout", {24'd0, bus.ram_dout}, 32'h12);
    tick();
    chk1 ("bs_wr_done", bus.ram_wr,        1'b0);
    chk1 ("bs_avail",   bus.mem_available, 1'b1);
    chk32("bs_rdata",   bus.mem_rdata,     32'd0);
    tick();
    chk32("bs_ram1F0", {24'd0, ram[9'h1F0]}, 32'h12);
    chk32("bs_ram1F1", {24'd0, ram[9'h1F1]}, 32'h5A);

    // Halfword load at 0x20, zero-extended
    mem_req(32'h20, 1'b0, 32'd0, 2'd2);
    tick();
    mem_req(32'd0, 1'b0, 32'd0, 2'd0);
    tick(); tick();
    chk1 ("hl_avail_early", bus.mem_available, 1'b0);
    tick();
    chk1 ("hl_avail", bus.mem_available, 1'b1);
    chk32("hl_rdata", bus.mem_rdata,     32'h0000FF80);
    tick();

    // Simultaneous IF and MEM requests: MEM first
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    mem_req(32'h40, 1'b0, 32'd0, 2'd3);
    tick();
    mem_req(32'd0, 1'b0, 32'd0, 2'd0);
    chk32("pr_mem_a",   bus.ram_a,       32'h40);
    chk1 ("pr_mem_work", bus.mem_working, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    chk1 ("pr_mem_avail", bus.mem_available, 1'b1);
    chk32("pr_mem_rdata", bus.mem_rdata,     32'h04030201);
    chk1 ("pr_if_quiet",  bus.if_available,  1'b0);
    tick();
    chk1 ("pr_idle_needed", bus.addr_needed, 1'b1);
    tick();
    bus.if_req = 1'b0;
    chk32("pr_if_a",     bus.ram_a,       32'h0);
    chk1 ("pr_if_work",  bus.mem_working, 1'b0);
    chk1 ("pr_if_needed", bus.addr_needed, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk1 ("pr_if_avail", bus.if_available,  1'b1);
    chk32("pr_if_inst",  bus.if_inst,       32'h00000513);
    chk1 ("pr_if_work_done", bus.mem_working, 1'b0);
    chk1 ("pr_if_no_mem", bus.mem_available, 1'b0);
    tick();
    chk1 ("pr_if_avail_off", bus.if_available, 1'b0);

    // IF fetch flushed in READ cycle 2: reads finish, no pulse
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    tick();
    bus.if_req = 1'b0;
    tick(); tick();
    bus.if_clear = 1'b1;
    tick();
    bus.if_clear = 1'b0;
    chk32("fl_a3", bus.ram_a, 32'h103);
    tick(); tick();
    chk1("fl_no_avail",  bus.if_available, 1'b0);
    chk1("fl_needed_dn", bus.addr_needed,  1'b0);
    tick();
    chk1("fl_needed_back", bus.addr_needed, 1'b1);

    // Word load wrapping past the top of the address space
    mem_req(32'hFFFF_FFFF, 1'b0, 32'd0, 2'd3);
    tick();
    mem_req(32'd0, 1'b0, 32'd0, 2'd0);
    chk32("wr_a0", bus.ram_a, 32'hFFFF_FFFF);
    tick();
    chk32("wr_a1", bus.ram_a, 32'h0000_0000);
    for (int i = 0; i < 4; i++) tick();
    chk1 ("wr_avail", bus.mem_available, 1'b1);
    chk32("wr_rdata", bus.mem_rdata,     32'h000513EE);
    tick();

    // Async reset during cycle 1 of a word store
    mem_req(32'h80, 1'b1, 32'h11223344, 2'd3);
    tick();
    mem_req(32'd0, 1'b0, 32'd0, 2'd0);
    chk1("rs_wr0", bus.ram_wr, 1'b1);
    tick();
    chk32("rs_a1", bus.ram_a, 32'h81);
    #1 rst = 1'b0;
    #1;
    chk1("rs_wr_async",      bus.ram_wr,      1'b0);
    chk1("rs_working_async", bus.mem_working, 1'b0);
    chk1("rs_needed_async",  bus.addr_needed, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk1("rs_needed_after", bus.addr_needed, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk1("rs_no_avail", bus.mem_available, 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
